delay_step_accumulator: RTL and testbench

- Sits directly downstream of the L_kn comparator-term generator and consumes its per-element `output_terms` vector once per scan point.
- Keeps, for each element n, an integer sample delay D_n and a fractional residual S_n. It uses a midpoint-style square-root recurrence: S_n += L_kn; while S_n ≥ 2·D_n+1, subtract 2·D_n+1 and increment D_n.
- Produces the updated per-element delay vector for the focusing/sample-select stage.
- Elements are processed serially through one shared adder/comparator.

---
 rtl/delay_pkg.sv | 21 ++
 rtl/delay_step_unit.sv | 58 +++++
 rtl/delay_step_accumulator.sv | 166 ++++++++++++++++
 tb/tb_delay_step_accumulator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and constants for the per-element delay step accumulator.
package delay_pkg;

  localparam int unsigned TermFracBits   = 4;
  localparam int unsigned DwTermDefault  = 21;
  localparam int unsigned DwResidual     = DwTermDefault + 2;
  localparam int unsigned DwDelayDefault = 12;

  typedef logic signed [DwResidual-1:0] residual_t;
  typedef logic [DwDelayDefault-1:0]    delay_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTerms,
    StAccum,
    StStep,
    StAck,
    StDone
  } state_e;

endpackage

// File: rtl/delay_step_unit.sv
// Shared combinational datapath: accumulates one term into a residual, or evaluates
// one midpoint step (subtract 2D+1, increment D) for the selected element.
module delay_step_unit
  import delay_pkg::*;
#(
  parameter int unsigned DwTerm   = DwTermDefault,
  parameter int unsigned DwDelay  = DwDelayDefault,
  parameter int unsigned MaxSteps = 2
) (
  input  logic signed [DwTerm+1:0] s_i,
  input  logic [DwDelay-1:0]       d_i,
  input  logic signed [DwTerm-1:0] term_i,
  input  logic [1:0]               c_i,
  input  logic                     phase_i,  // 0: accumulate term, 1: step evaluation
  output logic signed [DwTerm+1:0] s_o,
  output logic [DwDelay-1:0]       d_o,
  output logic                     step_taken_o,
  output logic                     overflow_o
);

  localparam int unsigned DwS = DwTerm + 2;

  logic signed [DwS:0]   sum;
  logic signed [DwS-1:0] thr;
  logic                  hit;

  always_comb begin
    s_o          = s_i;
    d_o          = d_i;
    step_taken_o = 1'b0;
    overflow_o   = 1'b0;
    sum          = {s_i[DwS-1], s_i} + {{3{term_i[DwTerm-1]}}, term_i};
    // Threshold (2D+1) in the residual's fixed-point format, always positive.
    thr          = '0;
    thr[DwDelay+TermFracBits:0] = {d_i, 1'b1, {TermFracBits{1'b0}}};
    hit          = (s_i >= thr);

    if (!phase_i) begin
      if (sum[DwS] != sum[DwS-1]) begin
        overflow_o = 1'b1;
        s_o        = sum[DwS] ? {1'b1, {(DwS-1){1'b0}}} : {1'b0, {(DwS-1){1'b1}}};
      end else begin
        s_o = sum[DwS-1:0];
      end
    end else if (hit && (c_i < 2'(MaxSteps))) begin
      s_o          = s_i - thr;
      step_taken_o = 1'b1;
      if (&d_i) begin
        overflow_o = 1'b1;
      end else begin
        d_o = d_i + 1'b1;
      end
    end else if (hit) begin
      overflow_o = 1'b1;
    end
  end

endmodule

// File: rtl/delay_step_accumulator.sv
// Per-element integer delay tracker: folds each scan point's L_kn terms into a residual
// and steps the delay via a midpoint square-root recurrence, one element at a time.
module delay_step_accumulator
  import delay_pkg::*;
#(
  parameter int unsigned DW_INTEGER   = 16,
  parameter int unsigned DW_FRACTION  = 8,
  parameter int unsigned DW_TERM      = DW_INTEGER + DW_FRACTION - 3,
  parameter int unsigned DW_DELAY     = 12,
  parameter int unsigned NUM_ELEMENTS = 64,
  parameter int unsigned MAX_STEPS    = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    configure,
  input  logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0]   init_delay,
  input  logic [NUM_ELEMENTS-1:0][DW_TERM-1:0]    terms,
  input  logic                                    terms_valid,
  input  logic                                    final_scanpoint,
  output logic                                    terms_ack,
  output logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0]   delay_out,
  output logic [NUM_ELEMENTS-1:0][1:0]            inc_out,
  output logic                                    out_valid,
  input  logic                                    out_ack,
  output logic                                    overflow
);

  localparam int unsigned DwS = DW_TERM + 2;
  localparam int unsigned Nw  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

  state_e               state_q, state_d;
  logic [Nw-1:0]        n_q, n_d;
  logic [1:0]           c_q, c_d;
  logic                 ovf_q, ovf_d;
  logic                 final_q, final_d;

  logic signed [DwS-1:0] s_q   [NUM_ELEMENTS];
  logic [DW_DELAY-1:0]   d_q   [NUM_ELEMENTS];
  logic [1:0]            inc_q [NUM_ELEMENTS];

  logic                  cfg_load, elem_we, inc_we, step_phase;
  logic signed [DwS-1:0] s_nx;
  logic [DW_DELAY-1:0]   d_nx;
  logic                  u_step, u_ovf;

  assign step_phase = (state_q == StStep);

  delay_step_unit #(
    .DwTerm   (DW_TERM),
    .DwDelay  (DW_DELAY),
    .MaxSteps (MAX_STEPS)
  ) u_step_unit (
    .s_i          (s_q[n_q]),
    .d_i          (d_q[n_q]),
    .term_i       (terms[n_q]),
    .c_i          (c_q),
    .phase_i      (step_phase),
    .s_o          (s_nx),
    .d_o          (d_nx),
    .step_taken_o (u_step),
    .overflow_o   (u_ovf)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    c_d      = c_q;
    ovf_d    = ovf_q;
    final_d  = final_q;
    cfg_load = 1'b0;
    elem_we  = 1'b0;
    inc_we   = 1'b0;

    // A configure pulse restarts the scanline from any state.
    if (configure) begin
      cfg_load = 1'b1;
      ovf_d    = 1'b0;
      state_d  = StWaitTerms;
    end else begin
      unique case (state_q)
        StIdle: ;
        StWaitTerms: begin
          if (terms_valid) begin
            n_d     = '0;
            state_d = StAccum;
          end
        end
        StAccum: begin
          elem_we = 1'b1;
          c_d     = '0;
          if (u_ovf) ovf_d = 1'b1;
          state_d = StStep;
        end
        StStep: begin
          if (u_ovf) ovf_d = 1'b1;
          if (u_step) begin
            elem_we = 1'b1;
            c_d     = c_q + 2'd1;
          end else begin
            inc_we = 1'b1;
            if (n_q == Nw'(NUM_ELEMENTS - 1)) begin
              state_d = StAck;
            end else begin
              n_d     = n_q + Nw'(1);
              state_d = StAccum;
            end
          end
        end
        StAck: begin
          final_d = final_scanpoint;
          state_d = StDone;
        end
        StDone: begin
          if (out_ack) state_d = final_q ? StIdle : StWaitTerms;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      final_q <= 1'b0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        s_q[i]   <= '0;
        d_q[i]   <= '0;
        inc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      final_q <= final_d;
      if (cfg_load) begin
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
          s_q[i]   <= '0;
          d_q[i]   <= init_delay[i];
          inc_q[i] <= '0;
        end
      end else begin
        if (elem_we) begin
          s_q[n_q] <= s_nx;
          d_q[n_q] <= d_nx;
        end
        if (inc_we) inc_q[n_q] <= c_q;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      delay_out[i] = d_q[i];
      inc_out[i]   = inc_q[i];
    end
  end

  assign terms_ack = (state_q == StAck);
  assign out_valid = (state_q == StDone);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_delay_step_accumulator.sv
// Self-checking bench: directed and random scan points against an arithmetic model of
// the delay/residual recurrence.
module tb_delay_step_accumulator;

  localparam int N  = 64;
  localparam int DW = 12;
  localparam int TW = 21;
  localparam longint SMax = (longint'(1) << 22) - 1;
  localparam longint SMin = -(longint'(1) << 22);

  logic clk = 1'b0;
  logic rst, configure, terms_valid, final_scanpoint, out_ack;
  logic terms_ack, out_valid, overflow;
  logic [N-1:0][DW-1:0] init_delay, delay_out;
  logic [N-1:0][TW-1:0] terms;
  logic [N-1:0][1:0]    inc_out;

  int tests = 0;
  int failed = 0;

  int     md[N];
  longint ms[N];
  int     minc[N];
  bit     movf;
  int     tv[N];
  int     ini[N];

  always #5 clk = ~clk;

  delay_step_accumulator dut (
    .clk             (clk),
    .rst             (rst),
    .configure       (configure),
    .init_delay      (init_delay),
    .terms           (terms),
    .terms_valid     (terms_valid),
    .final_scanpoint (final_scanpoint),
    .terms_ack       (terms_ack),
    .delay_out       (delay_out),
    .inc_out         (inc_out),
    .out_valid       (out_valid),
    .out_ack         (out_ack),
    .overflow        (overflow)
  );

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  endtask

  task automatic drive_terms();
    for (int n = 0; n < N; n++) begin
      logic [31:0] t;
      t = tv[n];
      terms[n] = t[TW-1:0];
    end
  endtask

  // Pulse configure with ini[] and reset the model; starts and ends at posedge+1.
  task automatic do_configure();
    for (int n = 0; n < N; n++) begin
      logic [31:0] t;
      t = ini[n];
      init_delay[n] = t[DW-1:0];
      md[n]   = ini[n];
      ms[n]   = 0;
      minc[n] = 0;
    end
    movf = 1'b0;
    configure = 1'b1;
    @(posedge clk);
    #1 configure = 1'b0;
  endtask

  // One scan point of the recurrence in plain arithmetic; returns expected latency.
  task automatic model_point(output int lat);
    lat = 2;
    for (int n = 0; n < N; n++) begin
      int c;
      ms[n] += tv[n];
      if (ms[n] > SMax) begin ms[n] = SMax; movf = 1'b1; end
      if (ms[n] < SMin) begin ms[n] = SMin; movf = 1'b1; end
      c = 0;
      while (c < 2 && ms[n] >= longint'(2 * md[n] + 1) * 16) begin
        ms[n] -= longint'(2 * md[n] + 1) * 16;
        if (md[n] == 4095) movf = 1'b1;
        else md[n]++;
        c++;
      end
      if (ms[n] >= longint'(2 * md[n] + 1) * 16) movf = 1'b1;
      minc[n] = c;
      lat += c + 2;
    end
  endtask

  task automatic check_state(input string tag);
    logic [767:0] ed;
    logic [127:0] ei;
    ed = '0;
    ei = '0;
    for (int n = 0; n < N; n++) begin
      logic [31:0] a, b;
      a = md[n];
      b = minc[n];
      ed[n*DW +: DW] = a[DW-1:0];
      ei[n*2 +: 2]   = b[1:0];
    end
    chk({tag, "_delay"}, delay_out, ed);
    chk({tag, "_inc"}, inc_out, ei);
    chk({tag, "_overflow"}, overflow, movf);
  endtask

  task automatic run_point(input string tag, input bit fin);
    int exp_lat, lat, acks;
    bit got;
    model_point(exp_lat);
    drive_terms();
    final_scanpoint = fin;
    terms_valid = 1'b1;
    lat = 0;
    acks = 0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (terms_ack) acks++;
      if (out_valid) got = 1'b1;
    end
    chk({tag, "_out_valid_seen"}, got, 1'b1);
    if (!got) finish_run();
    terms_valid = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_ack_count"}, acks, 1);
    check_state(tag);
    out_ack = 1'b1;
    @(posedge clk);
    #1 out_ack = 1'b0;
    final_scanpoint = 1'b0;
    chk({tag, "_out_valid_clear"}, out_valid, 1'b0);
  endtask

  task automatic set_all(input int v);
    for (int n = 0; n < N; n++) tv[n] = v;
  endtask

  task automatic set_ini(input int v);
    for (int n = 0; n < N; n++) ini[n] = v;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    configure = 1'b0;
    terms_valid = 1'b0;
    final_scanpoint = 1'b0;
    out_ack = 1'b0;
    init_delay = '0;
    terms = '0;

    // Reset held while every input toggles.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      configure = 1'($urandom);
      terms_valid = 1'($urandom);
      final_scanpoint = 1'($urandom);
      out_ack = 1'($urandom);
      for (int n = 0; n < N; n++) begin
        init_delay[n] = DW'($urandom);
        terms[n] = TW'($urandom);
      end
    end
    configure = 1'b0;
    terms_valid = 1'b0;
    final_scanpoint = 1'b0;
    out_ack = 1'b0;
    rst = 1'b0;
    chk("reset_delay", delay_out, '0);
    chk("reset_inc", inc_out, '0);
    chk("reset_flags", {terms_ack, out_valid, overflow}, 3'b000);

    // Configure alone must not produce an output.
    set_ini(0);
    do_configure();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (out_valid || terms_ack) seen++;
    end
    chk("cfg_alone_no_output", seen, 0);

    // Single step per point.
    set_ini(10);
    do_configure();
    set_all(21 * 16);
    run_point("one_step_a", 1'b0);
    set_all(23 * 16);
    run_point("one_step_b", 1'b0);

    // Two steps, then steps exhausted.
    do_configure();
    set_all(50 * 16);
    run_point("two_steps", 1'b0);
    do_configure();
    set_all(80 * 16);
    run_point("step_limit", 1'b0);

    // No-step points: zero and negative terms.
    do_configure();
    set_all(0);
    run_point("zero_terms", 1'b0);
    set_all(-5 * 16);
    run_point("neg_terms", 1'b0);

    // Mixed per-element terms over 8 points.
    do_configure();
    set_all(0);
    tv[0] = 21 * 16;
    tv[N-1] = 50 * 16;
    for (int p = 0; p < 8; p++) run_point($sformatf("mixed_%0d", p), 1'b0);

    // Random points, with elements near delay saturation and a residual driven to its limit.
    for (int n = 0; n < N; n++) ini[n] = $urandom_range(0, 4095);
    ini[1] = 4095;
    ini[2] = 4094;
    do_configure();
    for (int p = 0; p < 7; p++) begin
      for (int n = 0; n < N; n++) tv[n] = int'($urandom_range(0, 1900)) - 400;
      tv[1] = (1 << 20) - 1;
      tv[2] = 60 * 16 * 8191;
      if (tv[2] > (1 << 20) - 1) tv[2] = (1 << 20) - 1;
      tv[3] = -(1 << 20);
      run_point($sformatf("random_%0d", p), p == 6);
    end

    // Back in idle: terms_valid must be ignored.
    drive_terms();
    terms_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 if (out_valid || terms_ack) seen++;
    end
    terms_valid = 1'b0;
    chk("idle_ignores_terms", seen, 0);

    // Configure arriving mid-point aborts it and reloads.
    set_ini(10);
    do_configure();
    set_all(50 * 16);
    drive_terms();
    terms_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 terms_valid = 1'b0;
    for (int n = 0; n < N; n++) ini[n] = $urandom_range(0, 200);
    do_configure();
    check_state("reload");
    for (int n = 0; n < N; n++) tv[n] = int'($urandom_range(0, 2400)) - 300;
    run_point("after_reload", 1'b0);

    finish_run();
  end

endmodule
